// File: rtl/parity_pkg.sv
// Shared types and constants for the even-parity serial transmitter.
// Pure definitions: no latency, no flow control.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Clocks from the first start-bit clock to the end of the stop bit.
    function automatic int unsigned frame_clks(input int unsigned data_w,
                                               input int unsigned clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: bit_end strobes on the last clock of each CLKS_PER_BIT period.
// Combinational strobe from a registered count; no backpressure, idles at zero while run is low.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_end = run && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_serial_tx.sv
// Frames a word as start, LSB-first data, even parity, stop; tx_out low the clock after accept.
// Frame is (DATA_W+3)*CLKS_PER_BIT clocks; in_ready is high only in IDLE, so the source holds off mid-frame.
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              frame_done,
    output logic              parity_out
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_d, done_d, par_out_d;
    logic              accept, bit_end;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state_q != IDLE),
        .restart (accept),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_d     = par_q;
        done_d    = 1'b0;
        par_out_d = parity_out;
        tx_d      = IDLE_LEVEL;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    par_d   = 1'b0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d     = '0;
                        par_out_d = par_d;
                        state_d   = PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it lines up with state_q.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            tx_out     <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            parity_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            tx_out     <= tx_d;
            tx_busy    <= (state_d != IDLE);
            frame_done <= done_d;
            parity_out <= par_out_d;
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_parity_serial_tx;

    typedef struct {
        logic [7:0] dat;
        logic       par;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic       in_valid4 = 1'b0, in_valid1 = 1'b0;
    logic [7:0] in_data4 = '0, in_data1 = '0;
    logic       rdy4, tx4, busy4, done4, par4;
    logic       rdy1, tx1, busy1, done1, par1;

    exp_t q4[$];
    exp_t q1[$];
    int   n_cmp = 0, n_bad = 0;
    int   done_cnt4 = 0, done_cnt1 = 0, done_exp4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done4) done_cnt4++;
        if (done1) done_cnt1++;
    end

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(rdy4), .tx_out(tx4), .tx_busy(busy4), .frame_done(done4),
        .parity_out(par4));

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(rdy1), .tx_out(tx1), .tx_busy(busy1), .frame_done(done1),
        .parity_out(par1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input exp_t e, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.dat[k-1];
        if (k == 9) return e.par;
        return 1'b1;
    endfunction

    // Frame checker for the CLKS_PER_BIT=4 instance; a reset aborts the frame.
    initial begin : mon4
        exp_t e;
        bit   ab;
        forever begin
            @(negedge clk);
            if (rst_n && tx4 === 1'b0) begin
                if (q4.size() == 0) begin
                    chk("unexpected_frame4", q4.size(), 1);
                end else begin
                    e  = q4.pop_front();
                    ab = 1'b0;
                    chk("start_cycle4", cyc, e.acc);
                    for (int k = 0; k < 11 && !ab; k++) begin
                        for (int c = 0; c < 4 && !ab; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (!rst_n) ab = 1'b1;
                            else chk($sformatf("bit4_%0d", k), tx4, frame_bit(e, k));
                        end
                    end
                    if (!ab) begin
                        @(negedge clk);
                        chk("frame_done4", done4, 1);
                        chk("done_cycle4", cyc, e.acc + 44);
                        chk("parity_out4", par4, e.par);
                        done_exp4++;
                    end
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && tx1 === 1'b0) begin
                if (q1.size() == 0) begin
                    chk("unexpected_frame1", q1.size(), 1);
                end else begin
                    e = q1.pop_front();
                    chk("start_cycle1", cyc, e.acc);
                    for (int k = 0; k < 11; k++) begin
                        if (k != 0) @(negedge clk);
                        chk($sformatf("bit1_%0d", k), tx1, frame_bit(e, k));
                    end
                    @(negedge clk);
                    chk("frame_done1", done1, 1);
                    chk("done_cycle1", cyc, e.acc + 11);
                    chk("parity_out1", par1, e.par);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic send4(input logic [7:0] d, input logic p, output int acc);
        int n = 0;
        in_valid4 = 1'b1;
        in_data4  = d;
        while (!rdy4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout4", rdy4, 1);
        acc = cyc + 1;
        q4.push_back('{dat: d, par: p, acc: acc});
        @(negedge clk);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((busy4 || q4.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout4", busy4, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : drive
        int         acc_a, acc_b, d0, n;
        logic [7:0] words[4] = '{8'hA5, 8'h07, 8'h00, 8'hFF};
        logic       pars[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};

        #12;
        chk("rst_tx_out", tx4, 1);
        chk("rst_in_ready", rdy4, 1);
        chk("rst_tx_busy", busy4, 0);
        chk("rst_frame_done", done4, 0);
        chk("rst_parity_out", par4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send4(words[i], pars[i], acc_a);
            in_valid4 = 1'b0;
            chk("busy_after_accept", busy4, 1);
            chk("ready_after_accept", rdy4, 0);
            wait_idle4();
        end

        // Back-to-back with in_valid held high.
        send4(8'h3C, 1'b0, acc_a);
        send4(8'h81, 1'b0, acc_b);
        in_valid4 = 1'b0;
        chk("b2b_spacing", acc_b - acc_a, 45);
        wait_idle4();

        // A word offered mid-frame must be ignored.
        d0 = done_cnt4;
        send4(8'h01, 1'b1, acc_a);
        in_valid4 = 1'b0;
        repeat (10) @(negedge clk);
        in_valid4 = 1'b1;
        in_data4  = 8'h55;
        chk("ready_mid_frame", rdy4, 0);
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_idle4();
        chk("single_done", done_cnt4 - d0, 1);

        // Reset during data bit 4, then a clean frame.
        d0 = done_cnt4;
        send4(8'h5A, 1'b0, acc_a);
        in_valid4 = 1'b0;
        repeat (21) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_out", tx4, 1);
        chk("abort_in_ready", rdy4, 1);
        chk("abort_tx_busy", busy4, 0);
        chk("abort_parity_out", par4, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt4 - d0, 0);
        send4(8'hC3, 1'b0, acc_a);
        in_valid4 = 1'b0;
        wait_idle4();
        chk("done_count4", done_cnt4, done_exp4);

        // Single-clock bit period.
        in_valid1 = 1'b1;
        in_data1  = 8'h80;
        n = 0;
        while (!rdy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        q1.push_back('{dat: 8'h80, par: 1'b1, acc: cyc + 1});
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("done_count1", done_cnt1, 1);
        chk("queue_empty1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
